// File: rtl/cell_char_pkg.sv
// cell_char_pkg: shared types and helpers for cell characterisation sweeps
package cell_char_pkg;

    typedef enum logic [2:0] {
        IDLE,
        DRIVE,
        SETTLE,
        SAMPLE,
        REPORT,
        DONE
    } sweep_state_t;

    // OA221 truth table: Q = (IN1|IN2) & (IN3|IN4) & IN5, bit k = Q for vector k
    localparam logic [31:0] OA221_TT = 32'hEEE0_0000;

    // Reflected binary Gray code; callers cast to their own width
    function automatic logic [15:0] bin2gray(input logic [15:0] b);
        return b ^ (b >> 1);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// sat_counter: clearable up-counter that sticks at all-ones
module sat_counter #(
    parameter int W = 8
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_clr,
    input  logic         i_inc,
    output logic [W-1:0] o_count
);

    logic [W-1:0] r_count;

    // Clear wins over increment; increment stops at the maximum value
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            r_count <= '0;
        else if (i_clr)
            r_count <= '0;
        else if (i_inc && r_count != {W{1'b1}})
            r_count <= r_count + W'(1);
    end

    assign o_count = r_count;

endmodule

// File: rtl/cell_stim_sweep.sv
// cell_stim_sweep: walks every input vector of a combinational cell, samples and checks its output
module cell_stim_sweep
    import cell_char_pkg::*;
#(
    parameter int                      N_IN        = 5,
    parameter int                      SETTLE_CYC  = 4,
    parameter logic [(2**N_IN)-1:0]    TRUTH_TABLE = OA221_TT,
    parameter int                      CNT_W       = 8
) (
    input  logic             CLK,
    input  logic             RSTB,
    input  logic             start,
    input  logic             gray_mode,
    output logic [N_IN-1:0]  stim,
    input  logic             q_in,
    output logic             busy,
    output logic             done,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [N_IN-1:0]  res_vec,
    output logic             res_q,
    output logic             res_err,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] toggle_count
);

    localparam int              SW        = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam logic [SW-1:0]   SETTLE_LD = SW'(SETTLE_CYC - 1);
    localparam logic [N_IN:0]   LAST_IDX  = (N_IN + 1)'((2 ** N_IN) - 1);

    logic [1:0]      r_rst_sync;
    sweep_state_t    r_state;
    logic [N_IN:0]   r_idx;
    logic            r_gray;
    logic [SW-1:0]   r_settle;
    logic [N_IN-1:0] r_stim;
    logic            r_busy;
    logic            r_done;
    logic            r_res_valid;
    logic [N_IN-1:0] r_res_vec;
    logic            r_res_q;
    logic            r_res_err;

    logic            w_rst_n;
    logic            w_start_ok;
    logic            w_last;
    logic [N_IN-1:0] w_gray_vec;
    logic [N_IN-1:0] w_drive_vec;
    logic            w_err;
    logic            w_err_inc;
    logic            w_tog_inc;

    // Reset asserts immediately, releases two clocks after RSTB rises
    always_ff @(posedge CLK or negedge RSTB) begin
        if (!RSTB)
            r_rst_sync <= 2'b00;
        else
            r_rst_sync <= {r_rst_sync[0], 1'b1};
    end

    assign w_rst_n     = r_rst_sync[1];
    assign w_start_ok  = (r_state == IDLE) && start;
    assign w_last      = (r_idx == LAST_IDX);
    assign w_gray_vec  = N_IN'(bin2gray(16'(r_idx)));
    assign w_drive_vec = r_gray ? w_gray_vec : r_idx[N_IN-1:0];
    assign w_err       = q_in ^ TRUTH_TABLE[r_stim];
    assign w_err_inc   = (r_state == SAMPLE) && w_err;
    // The first vector has no predecessor, so it never counts as a toggle
    assign w_tog_inc   = (r_state == SAMPLE) && (r_idx != '0) && (q_in != r_res_q);

    // Sweep sequencer with all outputs registered
    always_ff @(posedge CLK or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_state     <= IDLE;
            r_idx       <= '0;
            r_gray      <= 1'b0;
            r_settle    <= '0;
            r_stim      <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_res_valid <= 1'b0;
            r_res_vec   <= '0;
            r_res_q     <= 1'b0;
            r_res_err   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_gray  <= gray_mode;
                        r_idx   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= DRIVE;
                    end
                end
                DRIVE: begin
                    r_stim   <= w_drive_vec;
                    r_settle <= SETTLE_LD;
                    r_state  <= SETTLE;
                end
                SETTLE: begin
                    if (r_settle == '0)
                        r_state <= SAMPLE;
                    else
                        r_settle <= r_settle - SW'(1);
                end
                SAMPLE: begin
                    r_res_q     <= q_in;
                    r_res_vec   <= r_stim;
                    r_res_err   <= w_err;
                    r_res_valid <= 1'b1;
                    r_state     <= REPORT;
                end
                REPORT: begin
                    if (res_ready) begin
                        r_res_valid <= 1'b0;
                        if (w_last) begin
                            r_done  <= 1'b1;
                            r_state <= DONE;
                        end else begin
                            r_idx   <= r_idx + (N_IN + 1)'(1);
                            r_state <= DRIVE;
                        end
                    end
                end
                DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    sat_counter #(.W(CNT_W)) u_err_cnt (
        .i_clk   (CLK),
        .i_rst_n (w_rst_n),
        .i_clr   (w_start_ok),
        .i_inc   (w_err_inc),
        .o_count (err_count)
    );

    sat_counter #(.W(CNT_W)) u_tog_cnt (
        .i_clk   (CLK),
        .i_rst_n (w_rst_n),
        .i_clr   (w_start_ok),
        .i_inc   (w_tog_inc),
        .o_count (toggle_count)
    );

    assign stim      = r_stim;
    assign busy      = r_busy;
    assign done      = r_done;
    assign res_valid = r_res_valid;
    assign res_vec   = r_res_vec;
    assign res_q     = r_res_q;
    assign res_err   = r_res_err;

endmodule

// File: tb/tb_cell_stim_sweep.sv
// tb_cell_stim_sweep: directed checks of the OA221 stimulus sweep
module tb_cell_stim_sweep;

    logic       CLK = 1'b0;
    logic       RSTB = 1'b0;
    logic       start = 1'b0;
    logic       gray_mode = 1'b0;
    logic       res_ready = 1'b1;
    logic       stuck0 = 1'b0;
    logic       q_in;
    logic [4:0] stim;
    logic [4:0] res_vec;
    logic       busy;
    logic       done;
    logic       res_valid;
    logic       res_q;
    logic       res_err;
    logic [7:0] err_count;
    logic [7:0] toggle_count;

    int n_cmp = 0;
    int n_bad = 0;

    logic [4:0] q_vec[$];
    logic       q_q[$];
    logic       q_err[$];

    function automatic logic oa221(input logic [4:0] v);
        return (v[0] | v[1]) & (v[2] | v[3]) & v[4];
    endfunction

    function automatic logic [4:0] gray5(input int i);
        logic [4:0] b;
        b = 5'(i);
        return b ^ (b >> 1);
    endfunction

    assign q_in = stuck0 ? 1'b0 : oa221(stim);

    always #5 CLK = ~CLK;

    cell_stim_sweep dut (
        .CLK          (CLK),
        .RSTB         (RSTB),
        .start        (start),
        .gray_mode    (gray_mode),
        .stim         (stim),
        .q_in         (q_in),
        .busy         (busy),
        .done         (done),
        .res_valid    (res_valid),
        .res_ready    (res_ready),
        .res_vec      (res_vec),
        .res_q        (res_q),
        .res_err      (res_err),
        .err_count    (err_count),
        .toggle_count (toggle_count)
    );

    always @(negedge CLK) begin
        if (RSTB && res_valid && res_ready) begin
            q_vec.push_back(res_vec);
            q_q.push_back(res_q);
            q_err.push_back(res_err);
        end
    end

    task automatic clear_beats();
        q_vec.delete();
        q_q.delete();
        q_err.delete();
    endtask

    task automatic kick(input logic g);
        start = 1'b1;
        gray_mode = g;
        @(posedge CLK);
        #1;
        start = 1'b0;
        gray_mode = ~g;
    endtask

    task automatic wait_done(input int budget, output int n, output logic hit);
        n = 0;
        hit = 1'b0;
        while (n < budget && !hit) begin
            @(posedge CLK);
            #1;
            n++;
            if (done === 1'b1) hit = 1'b1;
        end
    endtask

    task automatic test_reset();
        RSTB = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        n_cmp++;
        if ({busy, done, res_valid, res_q, res_err, stim, res_vec, err_count, toggle_count} !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs: got busy=%b done=%b valid=%b stim=%0d errc=%0d togc=%0d expected all 0",
                     busy, done, res_valid, stim, err_count, toggle_count);
        end
        RSTB = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        n_cmp++;
        if (busy !== 1'b0 || stim !== 5'd0) begin
            n_bad++;
            $display("FAIL idle_after_release: got busy=%b stim=%0d expected 0 0", busy, stim);
        end
    endtask

    task automatic test_binary();
        int n;
        logic hit;
        stuck0 = 1'b0;
        res_ready = 1'b1;
        clear_beats();
        kick(1'b0);
        wait_done(2000, n, hit);
        n_cmp++;
        if (!hit || n != 224) begin
            n_bad++;
            $display("FAIL bin_latency: got %0d cycles (done seen=%b) expected 224", n, hit);
        end
        n_cmp++;
        if (q_vec.size() != 32) begin
            n_bad++;
            $display("FAIL bin_beats: got %0d expected 32", q_vec.size());
        end
        for (int i = 0; i < q_vec.size(); i++) begin
            n_cmp++;
            if ({q_vec[i], q_q[i], q_err[i]} !== {5'(i), oa221(5'(i)), 1'b0}) begin
                n_bad++;
                $display("FAIL bin_beat%0d: got vec=%0d q=%b err=%b expected vec=%0d q=%b err=0",
                         i, q_vec[i], q_q[i], q_err[i], i, oa221(5'(i)));
            end
        end
        n_cmp++;
        if (err_count !== 8'd0) begin
            n_bad++;
            $display("FAIL bin_err_count: got %0d expected 0", err_count);
        end
        n_cmp++;
        if (toggle_count !== 8'd5) begin
            n_bad++;
            $display("FAIL bin_toggle_count: got %0d expected 5", toggle_count);
        end
        n_cmp++;
        if (stim !== 5'd31 || busy !== 1'b1) begin
            n_bad++;
            $display("FAIL bin_done_cycle: got stim=%0d busy=%b expected 31 1", stim, busy);
        end
        @(posedge CLK);
        #1;
        n_cmp++;
        if (done !== 1'b0 || busy !== 1'b0 || stim !== 5'd31) begin
            n_bad++;
            $display("FAIL bin_after_done: got done=%b busy=%b stim=%0d expected 0 0 31", done, busy, stim);
        end
    endtask

    task automatic test_gray();
        int n;
        logic hit;
        int bad_seq;
        int bad_step;
        int exp_tog;
        clear_beats();
        kick(1'b1);
        wait_done(2000, n, hit);
        n_cmp++;
        if (!hit || q_vec.size() != 32) begin
            n_bad++;
            $display("FAIL gray_beats: got %0d beats (done seen=%b) expected 32", q_vec.size(), hit);
        end
        bad_seq = 0;
        bad_step = 0;
        exp_tog = 0;
        for (int i = 0; i < q_vec.size(); i++) begin
            if ({q_vec[i], q_q[i], q_err[i]} !== {gray5(i), oa221(gray5(i)), 1'b0}) bad_seq++;
            if (i > 0 && $countones(q_vec[i] ^ q_vec[i-1]) != 1) bad_step++;
        end
        for (int i = 1; i < 32; i++)
            if (oa221(gray5(i)) != oa221(gray5(i - 1))) exp_tog++;
        n_cmp++;
        if (bad_seq != 0) begin
            n_bad++;
            $display("FAIL gray_sequence: got %0d wrong beats expected 0", bad_seq);
        end
        n_cmp++;
        if (bad_step != 0) begin
            n_bad++;
            $display("FAIL gray_one_bit: got %0d non-single-bit steps expected 0", bad_step);
        end
        n_cmp++;
        if (err_count !== 8'd0) begin
            n_bad++;
            $display("FAIL gray_err_count: got %0d expected 0", err_count);
        end
        n_cmp++;
        if (toggle_count !== 8'(exp_tog)) begin
            n_bad++;
            $display("FAIL gray_toggle_count: got %0d expected %0d", toggle_count, exp_tog);
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic test_q_stuck0();
        int n;
        logic hit;
        int n_err_beats;
        int bad_seq;
        stuck0 = 1'b1;
        clear_beats();
        kick(1'b0);
        wait_done(2000, n, hit);
        n_err_beats = 0;
        bad_seq = 0;
        for (int i = 0; i < q_vec.size(); i++) begin
            if (q_err[i] === 1'b1) n_err_beats++;
            if ({q_vec[i], q_q[i], q_err[i]} !== {5'(i), 1'b0, oa221(5'(i))}) bad_seq++;
        end
        n_cmp++;
        if (!hit || q_vec.size() != 32 || bad_seq != 0) begin
            n_bad++;
            $display("FAIL stuck0_beats: got %0d beats, %0d wrong expected 32, 0", q_vec.size(), bad_seq);
        end
        n_cmp++;
        if (n_err_beats != 9) begin
            n_bad++;
            $display("FAIL stuck0_err_beats: got %0d expected 9", n_err_beats);
        end
        n_cmp++;
        if (err_count !== 8'd9) begin
            n_bad++;
            $display("FAIL stuck0_err_count: got %0d expected 9", err_count);
        end
        n_cmp++;
        if (toggle_count !== 8'd0) begin
            n_bad++;
            $display("FAIL stuck0_toggle_count: got %0d expected 0", toggle_count);
        end
        stuck0 = 1'b0;
        @(posedge CLK);
        #1;
    endtask

    task automatic test_backpressure();
        int n;
        int k;
        int bad_hold;
        int bad_seq;
        logic hit;
        clear_beats();
        kick(1'b0);
        k = 0;
        while (stim !== 5'd3 && k < 200) begin
            @(posedge CLK);
            #1;
            k++;
        end
        res_ready = 1'b0;
        k = 0;
        while (res_valid !== 1'b1 && k < 50) begin
            @(posedge CLK);
            #1;
            k++;
        end
        n_cmp++;
        if (res_valid !== 1'b1 || res_vec !== 5'd3) begin
            n_bad++;
            $display("FAIL bp_reach_beat3: got valid=%b vec=%0d expected 1 3", res_valid, res_vec);
        end
        bad_hold = 0;
        repeat (10) begin
            @(posedge CLK);
            #1;
            if (res_valid !== 1'b1 || res_vec !== 5'd3 || res_q !== 1'b0 || stim !== 5'd3) bad_hold++;
        end
        n_cmp++;
        if (bad_hold != 0) begin
            n_bad++;
            $display("FAIL bp_hold: got %0d unstable cycles expected 0", bad_hold);
        end
        res_ready = 1'b1;
        wait_done(2000, n, hit);
        bad_seq = 0;
        for (int i = 0; i < q_vec.size(); i++)
            if (q_vec[i] !== 5'(i)) bad_seq++;
        n_cmp++;
        if (!hit || q_vec.size() != 32 || bad_seq != 0) begin
            n_bad++;
            $display("FAIL bp_no_loss: got %0d beats, %0d out of order expected 32, 0", q_vec.size(), bad_seq);
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic test_abort();
        int n;
        int k;
        int bad_seq;
        logic hit;
        stuck0 = 1'b1;
        kick(1'b0);
        k = 0;
        while (stim !== 5'd12 && k < 300) begin
            @(posedge CLK);
            #1;
            k++;
        end
        RSTB = 1'b0;
        #2;
        n_cmp++;
        if ({busy, done, res_valid, stim, res_vec, err_count, toggle_count} !== '0) begin
            n_bad++;
            $display("FAIL abort_outputs: got busy=%b valid=%b stim=%0d vec=%0d expected all 0",
                     busy, res_valid, stim, res_vec);
        end
        stuck0 = 1'b0;
        @(posedge CLK);
        #1;
        RSTB = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        clear_beats();
        kick(1'b0);
        wait_done(2000, n, hit);
        bad_seq = 0;
        for (int i = 0; i < q_vec.size(); i++)
            if ({q_vec[i], q_err[i]} !== {5'(i), 1'b0}) bad_seq++;
        n_cmp++;
        if (!hit || n != 224 || q_vec.size() != 32 || bad_seq != 0) begin
            n_bad++;
            $display("FAIL abort_resweep: got %0d cycles, %0d beats, %0d wrong expected 224, 32, 0",
                     n, q_vec.size(), bad_seq);
        end
        n_cmp++;
        if (err_count !== 8'd0 || toggle_count !== 8'd5) begin
            n_bad++;
            $display("FAIL abort_counts: got err=%0d tog=%0d expected 0 5", err_count, toggle_count);
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic test_start_ignored();
        int n;
        int bad_idle;
        logic hit;
        clear_beats();
        kick(1'b0);
        repeat (10) @(posedge CLK);
        #1;
        start = 1'b1;
        repeat (5) @(posedge CLK);
        #1;
        start = 1'b0;
        wait_done(2000, n, hit);
        n_cmp++;
        if (!hit || n + 15 != 224) begin
            n_bad++;
            $display("FAIL busy_start_latency: got %0d cycles expected 224", n + 15);
        end
        start = 1'b1;
        @(posedge CLK);
        #1;
        start = 1'b0;
        bad_idle = 0;
        repeat (20) begin
            if (busy !== 1'b0 || done !== 1'b0) bad_idle++;
            @(posedge CLK);
            #1;
        end
        n_cmp++;
        if (bad_idle != 0) begin
            n_bad++;
            $display("FAIL done_start_ignored: got %0d busy cycles expected 0", bad_idle);
        end
        n_cmp++;
        if (q_vec.size() != 32) begin
            n_bad++;
            $display("FAIL single_sweep_beats: got %0d expected 32", q_vec.size());
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        #1;
        test_reset();
        test_binary();
        test_gray();
        test_q_stuck0();
        test_backpressure();
        test_abort();
        test_start_ignored();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
